// File: rtl/flag_unit.sv
// flag_unit: architectural {V,N,Z} flag register, ID/EX control copy and
// flag RAW hazard detection for conditional branches resolved in ID.
module flag_unit #(
    parameter int unsigned DW   = 16,
    parameter int unsigned OP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [OP_W-1:0] id_opcode,
    input  logic            id_branch,
    input  logic [2:0]      id_cond,
    input  logic            pipe_stall,
    input  logic            ex_flush,
    input  logic [DW-1:0]   alu_result,
    input  logic            alu_ovfl,
    output logic [2:0]      F,
    output logic            flag_hazard,
    output logic            ex_sets_flags
);

    localparam int unsigned FW          = 3;
    localparam logic [2:0]  COND_ALWAYS = 3'b111;

    logic            ex_valid_q;
    logic [OP_W-1:0] ex_op_q;
    logic [FW-1:0]   mask_ex;
    logic [FW-1:0]   f_new;
    logic            we;

    // Per-opcode flag write mask, ordered {V,N,Z}.
    function automatic logic [FW-1:0] wmask(input logic [OP_W-1:0] op);
        logic [FW-1:0] m;
        m = '0;
        case (op)
            OP_W'(4'h0), OP_W'(4'h1):               m = 3'b111;
            OP_W'(4'h2), OP_W'(4'h4),
            OP_W'(4'h5), OP_W'(4'h6):               m = 3'b001;
            default:                                m = 3'b000;
        endcase
        return m;
    endfunction

    // Decode of the EX-stage instruction and hazard detection.
    always_comb begin
        mask_ex       = wmask(ex_op_q);
        ex_sets_flags = ex_valid_q & (mask_ex != '0);
        flag_hazard   = id_valid & id_branch & (id_cond != COND_ALWAYS) & ex_sets_flags;
        we            = ex_valid_q & ~pipe_stall;
        f_new         = {alu_ovfl, alu_result[DW-1], (alu_result == '0)};
    end

    // Flag register: only mask-selected bits take the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            F <= '0;
        end else if (we) begin
            F <= (f_new & mask_ex) | (F & ~mask_ex);
        end
    end

    // ID/EX control copy: flush > stall > hazard bubble > advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
        end else if (ex_flush) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= id_opcode;
        end else if (pipe_stall) begin
            ex_valid_q <= ex_valid_q;
            ex_op_q    <= ex_op_q;
        end else if (flag_hazard) begin
            ex_valid_q <= 1'b0;
        end else begin
            ex_valid_q <= id_valid;
            ex_op_q    <= id_opcode;
        end
    end

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed scoreboard bench for flag_unit.
module tb_flag_unit;

    localparam int unsigned DW   = 16;
    localparam int unsigned OP_W = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h2;
    localparam logic [3:0] OP_RED  = 4'h3;
    localparam logic [3:0] OP_PADD = 4'h7;
    localparam logic [3:0] OP_B    = 4'hC;

    typedef struct {
        string      tag;
        logic       haz;
        logic       sets;
        logic [2:0] f;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            id_valid;
    logic [OP_W-1:0] id_opcode;
    logic            id_branch;
    logic [2:0]      id_cond;
    logic            pipe_stall;
    logic            ex_flush;
    logic [DW-1:0]   alu_result;
    logic            alu_ovfl;
    logic [2:0]      F;
    logic            flag_hazard;
    logic            ex_sets_flags;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    flag_unit #(.DW(DW), .OP_W(OP_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_branch    (id_branch),
        .id_cond      (id_cond),
        .pipe_stall   (pipe_stall),
        .ex_flush     (ex_flush),
        .alu_result   (alu_result),
        .alu_ovfl     (alu_ovfl),
        .F            (F),
        .flag_hazard  (flag_hazard),
        .ex_sets_flags(ex_sets_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue what it should produce.
    task automatic step(input string tag, input logic r, input logic v, input logic [3:0] op,
                        input logic br, input logic [2:0] cond, input logic st, input logic fl,
                        input logic [15:0] res, input logic ovf,
                        input logic e_haz, input logic e_sets, input logic [2:0] e_f);
        exp_t e;
        @(negedge clk);
        rst        = r;
        id_valid   = v;
        id_opcode  = op;
        id_branch  = br;
        id_cond    = cond;
        pipe_stall = st;
        ex_flush   = fl;
        alu_result = res;
        alu_ovfl   = ovf;
        e.tag  = tag;
        e.haz  = e_haz;
        e.sets = e_sets;
        e.f    = e_f;
        sb.push_back(e);
    endtask

    task automatic drain();
        wait (sb.size() == 0);
        @(posedge clk);
        #2;
    endtask

    // Monitor: combinational outputs before the edge, F after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.tag, "/haz"},  16'(flag_hazard),   16'(e.haz));
                check({e.tag, "/sets"}, 16'(ex_sets_flags), 16'(e.sets));
                @(posedge clk);
                #1;
                check({e.tag, "/F"}, 16'(F), 16'(e.f));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; id_valid = 1'b1; id_opcode = OP_ADD; id_branch = 1'b1; id_cond = 3'b001;
        pipe_stall = 1'b0; ex_flush = 1'b0; alu_result = '0; alu_ovfl = 1'b0;

        //   tag            rst v  op       br cond    st fl result    ov  haz sets F
        step("rst0",        1, 1, OP_ADD,  1, 3'b001, 0, 0, 16'h0000, 0,  0,  0,  3'b000);
        step("rst1",        1, 1, OP_SUB,  1, 3'b001, 1, 0, 16'h8000, 1,  0,  0,  3'b000);
        for (int i = 0; i < 3; i++)
            step("idle",    0, 0, OP_ADD,  0, 3'b000, 0, 0, 16'h1234, 1,  0,  0,  3'b000);
        step("add_in",      0, 1, OP_ADD,  0, 3'b000, 0, 0, 16'hffff, 1,  0,  0,  3'b000);
        step("add_ex",      0, 1, OP_SUB,  0, 3'b000, 0, 0, 16'h0000, 0,  0,  1,  3'b001);
        step("sub_ex",      0, 1, OP_XOR,  0, 3'b000, 0, 0, 16'h8000, 1,  0,  1,  3'b110);
        step("xor_ex",      0, 1, OP_RED,  0, 3'b000, 0, 0, 16'h0000, 0,  0,  1,  3'b111);
        step("red_ex",      0, 1, OP_PADD, 0, 3'b000, 0, 0, 16'h0005, 0,  0,  0,  3'b111);
        step("padd_ex",     0, 1, OP_SUB,  0, 3'b000, 0, 0, 16'h0005, 0,  0,  0,  3'b111);
        step("haz_on",      0, 1, OP_B,    1, 3'b001, 0, 0, 16'h0001, 0,  1,  1,  3'b000);
        step("haz_off",     0, 1, OP_B,    1, 3'b001, 0, 0, 16'h0001, 0,  0,  0,  3'b000);
        step("br_ex",       0, 1, OP_SUB,  0, 3'b000, 0, 0, 16'h0000, 0,  0,  0,  3'b000);
        step("uncond",      0, 1, OP_B,    1, 3'b111, 0, 0, 16'h8000, 1,  0,  1,  3'b110);
        step("add_in2",     0, 1, OP_ADD,  0, 3'b000, 0, 0, 16'h0000, 0,  0,  0,  3'b110);
        for (int i = 0; i < 3; i++)
            step("stall",   0, 1, OP_B,    1, 3'b001, 1, 0, 16'h0000, 0,  1,  1,  3'b110);
        step("release",     0, 1, OP_B,    1, 3'b001, 0, 0, 16'h0000, 0,  1,  1,  3'b001);
        step("bubble",      0, 1, OP_B,    1, 3'b001, 0, 0, 16'h8000, 1,  0,  0,  3'b001);
        step("add_in3",     0, 1, OP_ADD,  0, 3'b000, 0, 0, 16'h0000, 0,  0,  0,  3'b001);
        step("flush",       0, 1, OP_SUB,  0, 3'b000, 0, 1, 16'h8000, 0,  0,  1,  3'b010);
        step("flush_stall", 0, 1, OP_ADD,  1, 3'b001, 1, 1, 16'h0000, 0,  0,  0,  3'b010);
        step("post_flush",  0, 0, OP_ADD,  0, 3'b000, 0, 0, 16'h0000, 0,  0,  0,  3'b010);
        step("add_in4",     0, 1, OP_ADD,  0, 3'b000, 0, 0, 16'h0000, 0,  0,  0,  3'b010);
        step("flush_haz",   0, 1, OP_B,    1, 3'b001, 0, 1, 16'h0000, 1,  1,  1,  3'b101);
        step("after_fh",    0, 1, OP_ADD,  0, 3'b000, 0, 0, 16'h0000, 0,  0,  0,  3'b101);
        drain();

        // ADD sits in EX with F=101; reset mid-cycle must clear F at once.
        @(negedge clk);
        id_valid   = 1'b0;
        alu_result = 16'h8000;
        alu_ovfl   = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst/F",    16'(F),             16'(3'b000));
        check("async_rst/sets", 16'(ex_sets_flags), 16'(1'b0));
        check("async_rst/haz",  16'(flag_hazard),   16'(1'b0));
        @(posedge clk);
        #1;
        check("rst_hold/F",     16'(F),             16'(3'b000));

        step("post_rst",    0, 0, OP_ADD,  0, 3'b000, 0, 0, 16'h8000, 1,  0,  0,  3'b000);
        step("add_in5",     0, 1, OP_ADD,  0, 3'b000, 0, 0, 16'h8000, 1,  0,  0,  3'b000);
        step("add_ex5",     0, 0, OP_ADD,  0, 3'b000, 0, 0, 16'h8000, 0,  0,  1,  3'b010);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
